// File: rtl/anton_neopixel_frame_scheduler_pkg.sv
// Shared encodings and default widths for the NeoPixel frame scheduler.
package anton_neopixel_frame_scheduler_pkg;

  localparam logic [1:0] ENUM_SCHED_IDLE   = 2'd0;
  localparam logic [1:0] ENUM_SCHED_INIT   = 2'd1;
  localparam logic [1:0] ENUM_SCHED_STREAM = 2'd2;
  localparam logic [1:0] ENUM_SCHED_GAP    = 2'd3;

  localparam int unsigned GAP_BITS_DEFAULT       = 16;
  localparam int unsigned FRAME_CNT_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle   = ENUM_SCHED_IDLE,
    StInit   = ENUM_SCHED_INIT,
    StStream = ENUM_SCHED_STREAM,
    StGap    = ENUM_SCHED_GAP
  } sched_state_e;

endpackage

// File: rtl/anton_neopixel_frame_scheduler_if.sv
// Command/config/stream bundle for the frame scheduler.
// ANTON_DOUBLE_BUFFER_EN adds cmd_swap, bank_sel and swap_pending.
interface anton_neopixel_frame_scheduler_if
  import anton_neopixel_frame_scheduler_pkg::*;
#(
  parameter int unsigned GAP_BITS       = GAP_BITS_DEFAULT,
  parameter int unsigned FRAME_CNT_BITS = FRAME_CNT_BITS_DEFAULT
);
  logic                      cmd_start;
  logic                      cmd_stop;
  logic                      cmd_abort;
  logic                      cfg_loop;
  logic [GAP_BITS-1:0]       cfg_gap;
  logic                      stream_pixel_of;
  logic                      stream_sync_of;
  logic                      ctrl_init;
  logic                      ctrl_run;
  logic                      busy;
  logic                      frame_done;
  logic [FRAME_CNT_BITS-1:0] frame_count;
  logic                      stop_pending;
`ifdef ANTON_DOUBLE_BUFFER_EN
  logic                      cmd_swap;
  logic                      bank_sel;
  logic                      swap_pending;
`endif

  modport master (
    output cmd_start, cmd_stop, cmd_abort, cfg_loop, cfg_gap, stream_pixel_of, stream_sync_of,
`ifdef ANTON_DOUBLE_BUFFER_EN
    output cmd_swap,
    input  bank_sel, swap_pending,
`endif
    input  ctrl_init, ctrl_run, busy, frame_done, frame_count, stop_pending
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_abort, cfg_loop, cfg_gap, stream_pixel_of, stream_sync_of,
`ifdef ANTON_DOUBLE_BUFFER_EN
    input  cmd_swap,
    output bank_sel, swap_pending,
`endif
    output ctrl_init, ctrl_run, busy, frame_done, frame_count, stop_pending
  );

endinterface

// File: rtl/anton_neopixel_gap_timer.sv
// Load/decrement down-counter timing the run-low gap between frames.
module anton_neopixel_gap_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             expire_o
);
  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiring on 1 makes the gap last exactly the loaded number of cycles.
  assign count_o  = count_q;
  assign expire_o = (count_q == Width'(1));

endmodule

// File: rtl/anton_neopixel_frame_scheduler.sv
// Frame sequencer for the NeoPixel stream engine: init/run control, gaps, stop and abort.
// ANTON_DOUBLE_BUFFER_EN enables bank swapping at frame boundaries.
module anton_neopixel_frame_scheduler
  import anton_neopixel_frame_scheduler_pkg::*;
#(
  parameter int unsigned GAP_BITS       = GAP_BITS_DEFAULT,
  parameter int unsigned FRAME_CNT_BITS = FRAME_CNT_BITS_DEFAULT
) (
  input  logic                             clk7mhz,
  input  logic                             rstn,
  anton_neopixel_frame_scheduler_if.slave  bus
);
  sched_state_e              state_d, state_q;
  logic                      stop_d, stop_q;
  logic                      abort_d, abort_q;
  logic [FRAME_CNT_BITS-1:0] count_d, count_q;
  logic                      frame_done;
  logic                      gap_load, gap_dec, gap_expire;
  logic [GAP_BITS-1:0]       gap_count;
  logic                      unused_pixel_of;

  // The engine enters its latch phase on its own; pixel_of is informational here.
  assign unused_pixel_of = bus.stream_pixel_of ^ (^gap_count);

  anton_neopixel_gap_timer #(
    .Width (GAP_BITS)
  ) u_gap_timer (
    .clk_i      (clk7mhz),
    .rst_ni     (rstn),
    .load_i     (gap_load),
    .load_val_i (bus.cfg_gap),
    .dec_i      (gap_dec),
    .count_o    (gap_count),
    .expire_o   (gap_expire)
  );

  always_comb begin
    state_d    = state_q;
    stop_d     = stop_q;
    abort_d    = abort_q;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    frame_done = 1'b0;
    if (state_q == StIdle) begin
      abort_d = 1'b0;
      if (bus.cmd_start && !bus.cmd_abort) begin
        state_d = StInit;
      end
    end else if (bus.cmd_abort) begin
      // One ctrl_init cycle lets the engine clear its indexes before idling.
      state_d = StInit;
      abort_d = 1'b1;
      stop_d  = 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (abort_q) begin
            state_d = StIdle;
            abort_d = 1'b0;
            stop_d  = 1'b0;
          end else begin
            state_d = StStream;
            if (bus.cmd_stop) stop_d = 1'b1;
          end
        end
        StStream: begin
          if (bus.cmd_stop) stop_d = 1'b1;
          if (bus.stream_sync_of) begin
            frame_done = 1'b1;
            if (!bus.cfg_loop || stop_q || bus.cmd_stop) begin
              state_d = StIdle;
              stop_d  = 1'b0;
            end else if (bus.cfg_gap != '0) begin
              state_d  = StGap;
              gap_load = 1'b1;
            end
          end
        end
        StGap: begin
          gap_dec = 1'b1;
          if (bus.cmd_stop) begin
            state_d = StIdle;
            stop_d  = 1'b0;
          end else if (gap_expire) begin
            state_d = StStream;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign count_d = frame_done ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      stop_q  <= 1'b0;
      abort_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      abort_q <= abort_d;
      count_q <= count_d;
    end
  end

  assign bus.ctrl_init    = (state_q == StInit);
  assign bus.ctrl_run     = (state_q == StStream);
  assign bus.busy         = (state_q != StIdle);
  assign bus.frame_done   = frame_done;
  assign bus.frame_count  = count_q;
  assign bus.stop_pending = stop_q;

`ifdef ANTON_DOUBLE_BUFFER_EN
  logic bank_d, bank_q;
  logic swap_d, swap_q;

  always_comb begin
    bank_d = bank_q;
    swap_d = swap_q;
    if (bus.busy && bus.cmd_abort) begin
      swap_d = 1'b0;
    end else if (swap_q && (frame_done ||
                 (state_q == StIdle && bus.cmd_start && !bus.cmd_abort))) begin
      bank_d = ~bank_q;
      swap_d = bus.cmd_swap;
    end else if (bus.cmd_swap) begin
      swap_d = 1'b1;
    end
  end

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      bank_q <= 1'b0;
      swap_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      swap_q <= swap_d;
    end
  end

  assign bus.bank_sel     = bank_q;
  assign bus.swap_pending = swap_q;
`endif

endmodule

// File: doc/anton_neopixel_frame_scheduler.md
Name: anton_neopixel_frame_scheduler

Overview:
- Sequences the NeoPixel stream engine frame by frame: drives its init/run controls, watches its end-of-frame and end-of-reset flags, and inserts a programmable inter-frame gap.
- Supports one-shot and continuous refresh, graceful stop at a frame boundary, and immediate abort.
- Sits between the APB register file (commands and config) and the stream logic (ctrl_init/ctrl_run in; pixel_of/sync_of out).

Parameters:
- GAP_BITS, 16, width of the inter-frame gap counter in clk7mhz cycles.
- FRAME_CNT_BITS, 16, width of the wrapping frame counter.

Ports:
- clk7mhz  in  1  sole clock (7 MHz).
- rstn  in  1  asynchronous active-low reset.
- cmd_start  in  1  one-cycle pulse: begin streaming.
- cmd_stop  in  1  one-cycle pulse: stop after the current frame completes.
- cmd_abort  in  1  one-cycle pulse: stop immediately.
- cfg_loop  in  1  1 = continuous refresh, 0 = single frame.
- cfg_gap  in  GAP_BITS  idle cycles between frames, with run low.
- stream_pixel_of  in  1  last bit of the last pixel is completing.
- stream_sync_of  in  1  reset/latch delay has completed.
- ctrl_init  out  1  to stream logic: clears its indexes.
- ctrl_run  out  1  to stream logic: enables streaming.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame's reset period ends.
- frame_count  out  FRAME_CNT_BITS  completed frames; wraps.
- stop_pending  out  1  a graceful stop is latched.

Behaviour:
- Reset values: state = IDLE; all outputs 0; gap counter 0.
- States: IDLE, INIT, STREAM, GAP.
- IDLE:
  - ctrl_init = 0, ctrl_run = 0.
  - cmd_start moves to INIT on the next edge.
  - cmd_stop and cmd_abort are ignored.
- INIT:
  - Lasts exactly 1 cycle; ctrl_init = 1, ctrl_run = 0.
  - Always goes to STREAM.
- STREAM:
  - ctrl_run = 1.
  - stream_pixel_of is monitored only; the engine enters its reset phase itself.
  - On stream_sync_of: frame_done pulses in the same cycle (combinational on state and flag); frame_count increments at that edge.
  - Next state on stream_sync_of: IDLE if cfg_loop = 0 or stop_pending = 1 (stop_pending clears); otherwise GAP if cfg_gap != 0; otherwise stay in STREAM (back-to-back frames, no init needed).
- GAP:
  - ctrl_run = 0; the counter loads cfg_gap on entry and decrements each cycle.
  - On reaching 1, go to STREAM. The gap is exactly cfg_gap cycles with run low.
  - A cfg_gap change mid-gap does not affect the current count.
- cmd_stop:
  - Sets stop_pending in INIT, STREAM or GAP.
  - In GAP it takes effect immediately: go to IDLE and clear stop_pending, with no extra frame.
- cmd_abort:
  - Highest priority, from any non-IDLE state.
  - Next state is INIT-then-IDLE (one ctrl_init cycle, so the engine's indexes clear); stop_pending clears.
  - No frame_done pulse and no count increment.
- Simultaneous events:
  - cmd_start in the same cycle as cmd_abort: abort wins.
  - cmd_start while busy: ignored.
  - stream_sync_of in the same cycle as cmd_stop: the frame completes, then go to IDLE.
- rstn asserted mid-frame forces IDLE asynchronously, with ctrl_run low immediately.

Optional Feature:
- ANTON_DOUBLE_BUFFER_EN defined:
  - Adds input cmd_swap (pulse) and outputs bank_sel and swap_pending.
  - cmd_swap sets swap_pending.
  - bank_sel toggles only at the edge where frame_done is high, or at the next cmd_start if IDLE; swap_pending then clears.
  - Abort also clears swap_pending without toggling.
  - bank_sel resets to 0.
- Undefined: these ports are absent and the single-bank behaviour above applies.

Decomposition:
- Shared header anton_common.vh gains:
  - state encodings ENUM_SCHED_IDLE/INIT/STREAM/GAP (2-bit);
  - GAP_BITS_DEFAULT and FRAME_CNT_BITS_DEFAULT.
- One sub-module: anton_neopixel_gap_timer (load/decrement/expire down-counter), instantiated in GAP.

Test Plan:
- Single shot: cfg_loop = 0, cmd_start → init high 1 cycle, run high until sync_of; frame_done once, frame_count = 1, busy falls the cycle after.
- Loop with gap: cfg_loop = 1, cfg_gap = 10 → between sync_of and run rising, exactly 10 cycles run low; frame_count = 3 after 3 syncs.
- Back-to-back: cfg_gap = 0 → run never drops across 2 frames; no init pulse between frames.
- Graceful stop: cmd_stop mid-STREAM → stop_pending = 1, frame finishes, frame_done pulses, IDLE; cmd_stop in GAP → IDLE immediately, count unchanged.
- Abort: cmd_abort mid-frame → run drops next cycle, one init cycle, IDLE; no frame_done; abort with start in the same cycle stays IDLE.
- Async reset: rstn low mid-STREAM → run = 0 without a clock edge; all outputs 0. With ANTON_DOUBLE_BUFFER_EN: a cmd_swap mid-frame toggles bank_sel exactly at frame_done.
